// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA scan-out engine: frame-total helpers,
// stream FSM state and the colour-bar table used when VGA_TEST_PATTERN_EN is defined.
package vga_pkg;

   typedef enum logic {
      RESYNC = 1'b0,
      RUN    = 1'b1
   } vga_state_t;

   function automatic int h_total(input int active, input int fp, input int sync_w, input int bp);
      return active + fp + sync_w + bp;
   endfunction

   function automatic int v_total(input int active, input int fp, input int sync_w, input int bp);
      return active + fp + sync_w + bp;
   endfunction

   // {R,G,B} on/off flags, left to right: white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [2:0] BAR_RGB [0:7] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                           3'b101, 3'b100, 3'b001, 3'b000};

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous show-ahead FIFO: head always presents the oldest entry while not empty.
module vga_pixel_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vga_stream_out.sv
// VGA scan-out: Avalon-ST {R,G,B} sink through a pixel FIFO onto DAC pins, frame-aligned on sop.
// Optional colour-bar generator and test_mode port when VGA_TEST_PATTERN_EN is defined.
module vga_stream_out
   import vga_pkg::*;
#(
   parameter int COLOR_W    = 8,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int HS_POL     = 0,
   parameter int VS_POL     = 0,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                 test_mode,
`endif
   input  logic [3*COLOR_W-1:0] in_data,
   input  logic                 in_sop,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 underflow,
   input  logic                 clr_underflow,
   output logic [COLOR_W-1:0]   vga_r,
   output logic [COLOR_W-1:0]   vga_g,
   output logic [COLOR_W-1:0]   vga_b,
   output logic                 vga_hs,
   output logic                 vga_vs,
   output logic                 vga_blank_n,
   output logic                 vga_sync_n,
   output vga_state_t           dbg_state
);

   localparam int   H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int   V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int   HW      = $clog2(H_TOTAL);
   localparam int   VW      = $clog2(V_TOTAL);
   localparam int   DW      = 3 * COLOR_W;
   localparam int   BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
   localparam logic HS_ON   = (HS_POL != 0);
   localparam logic VS_ON   = (VS_POL != 0);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   vga_state_t    state;
   logic          tm;
   logic          active, at_origin, hs_act, vs_act;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [DW:0]   fifo_head;
   logic          head_sop;
   logic [DW-1:0] head_data;
   logic          start_frame, lose_sync, uf_set;
   logic [DW-1:0] pix, bar_pix;
   logic [2:0]    bar_idx, bar_flags;

`ifdef VGA_TEST_PATTERN_EN
   assign tm = test_mode;
`else
   assign tm = 1'b0;
`endif

   // Handshake: a word transfers on a clock where in_valid && in_ready. in_ready comes
   // from the registered FIFO count only, so a pop in the same cycle never frees a slot early.
   assign in_ready   = !reset && !fifo_full && !tm;
   assign vga_sync_n = 1'b0;
   assign dbg_state  = state;

   assign active    = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
   assign at_origin = (h_cnt == '0) && (v_cnt == '0);
   assign hs_act    = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
   assign vs_act    = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
   assign head_sop  = fifo_head[DW];
   assign head_data = fifo_head[DW-1:0];

   assign bar_idx   = (int'(h_cnt) / BAR_W > 7) ? 3'd7 : 3'(int'(h_cnt) / BAR_W);
   assign bar_flags = BAR_RGB[bar_idx];
   assign bar_pix   = {{COLOR_W{bar_flags[2]}}, {COLOR_W{bar_flags[1]}}, {COLOR_W{bar_flags[0]}}};

   vga_pixel_fifo #(
      .WIDTH (DW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_valid && in_ready),
      .pop   (fifo_pop),
      .din   ({in_sop, in_data}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // While out of sync, stale mid-frame words drain one per clock until a sop meets (0,0).
   always_comb begin
      fifo_pop    = 1'b0;
      start_frame = 1'b0;
      lose_sync   = 1'b0;
      uf_set      = 1'b0;
      pix         = '0;
      if (tm) begin
         if (active) pix = bar_pix;
      end else if (state == RESYNC) begin
         if (!fifo_empty) begin
            if (!head_sop) begin
               fifo_pop = 1'b1;
            end else if (at_origin) begin
               fifo_pop    = 1'b1;
               pix         = head_data;
               start_frame = 1'b1;
            end
         end
      end else if (active) begin
         if (fifo_empty) begin
            uf_set    = 1'b1;
            lose_sync = 1'b1;
         end else if (head_sop && !at_origin) begin
            lose_sync = 1'b1;
         end else begin
            fifo_pop = 1'b1;
            pix      = head_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         state       <= RESYNC;
         underflow   <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_blank_n <= 1'b0;
         vga_hs      <= ~HS_ON;
         vga_vs      <= ~VS_ON;
      end else begin
         if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end

         if (tm || lose_sync)  state <= RESYNC;
         else if (start_frame) state <= RUN;

         if (uf_set)                     underflow <= 1'b1;
         else if (clr_underflow && !tm)  underflow <= 1'b0;

         {vga_r, vga_g, vga_b} <= pix;
         vga_blank_n           <= active;
         vga_hs                <= hs_act ? HS_ON : ~HS_ON;
         vga_vs                <= vs_act ? VS_ON : ~VS_ON;
      end
   end

endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out on a tiny raster; a queue-based frame model predicts every output clock.
module tb_vga_stream_out;

   localparam int CW = 8;
`ifdef VGA_TEST_PATTERN_EN
   localparam int HA = 16;
`else
   localparam int HA = 4;
`endif
   localparam int HF = 1, HSW = 1, HB = 1;
   localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
   localparam int DEPTH    = 4;
   localparam int HT       = HA + HF + HSW + HB;
   localparam int VT       = VA + VF + VSW + VB;
   localparam int FRAME_PX = HA * VA;
   localparam int BARW     = (HA >= 8) ? HA / 8 : 1;
   localparam int DW       = 3 * CW;
   localparam int W        = DW + 7;

   // clock / reset and stimulus signals
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          test_mode = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_sop = 1'b0;
   logic          in_valid = 1'b0;
   logic          clr_underflow = 1'b0;
   logic          in_ready, underflow;
   logic [CW-1:0] vga_r, vga_g, vga_b;
   logic          vga_hs, vga_vs, vga_blank_n, vga_sync_n;
   vga_pkg::vga_state_t dbg_state;

   always #5 clk = ~clk;

   vga_stream_out #(
      .COLOR_W(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .HS_POL(0), .VS_POL(0), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode(test_mode),
`endif
      .in_data(in_data), .in_sop(in_sop), .in_valid(in_valid), .in_ready(in_ready),
      .underflow(underflow), .clr_underflow(clr_underflow),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_fail = 0;
   int n_printed = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_printed < 40) $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
         n_printed++;
      end
   endtask

   // reference model: time-indexed raster plus a queue of accepted {sop,data} words
   logic [DW:0]   mq[$];
   logic [W-1:0]  exp_q[$];
   bit            synced;
   bit            uf_m;
   int            t;
   logic [DW-1:0] bar_color [8] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                                   24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};

   always @(posedge clk) begin
      int h, v, bi;
      bit act, at0, accept, uf_set, hs_e, vs_e;
      logic [DW-1:0] pix;
      logic [DW:0] hd;
      if (reset) begin
         mq.delete();
         synced = 0;
         uf_m = 0;
         t = 0;
         exp_q.push_back({{DW{1'b0}}, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0});
      end else begin
         h = t % HT;
         v = (t / HT) % VT;
         act = (h < HA) && (v < VA);
         at0 = (h == 0) && (v == 0);
         accept = in_valid && !test_mode && (mq.size() < DEPTH);
         uf_set = 0;
         pix = '0;
         if (test_mode) begin
            bi = h / BARW;
            if (bi > 7) bi = 7;
            if (act) pix = bar_color[bi];
            synced = 0;
         end else if (!synced) begin
            if (mq.size() > 0) begin
               hd = mq[0];
               if (!hd[DW]) begin
                  void'(mq.pop_front());
               end else if (at0) begin
                  hd = mq.pop_front();
                  pix = hd[DW-1:0];
                  synced = 1;
               end
            end
         end else if (act) begin
            if (mq.size() == 0) begin
               uf_set = 1;
               synced = 0;
            end else if (mq[0][DW] && !at0) begin
               synced = 0;
            end else begin
               hd = mq.pop_front();
               pix = hd[DW-1:0];
            end
         end
         if (accept) mq.push_back({in_sop, in_data});
         if (uf_set) uf_m = 1;
         else if (clr_underflow && !test_mode) uf_m = 0;
         hs_e = !((h >= HA + HF) && (h < HA + HF + HSW));
         vs_e = !((v >= VA + VF) && (v < VA + VF + VSW));
         exp_q.push_back({pix, hs_e, vs_e, act, uf_m, 3'(mq.size())});
         t++;
      end
   end

   // monitor: one expected record per clock, compared mid-cycle
   always @(negedge clk) begin
      logic [W-1:0] e;
      bit rdy_e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("video", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, underflow}, e[W-1:3]);
         rdy_e = !reset && !test_mode && (int'(e[2:0]) < DEPTH);
         check("in_ready", in_ready, rdy_e);
         check("sync_n", vga_sync_n, 1'b0);
      end
   end

   // driver tasks: every task starts and ends 1 time unit after a rising edge
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      clr_underflow = 1'b1;
      idle(1);
      clr_underflow = 1'b0;
   endtask

   task automatic send(input bit sop, input logic [DW-1:0] d);
      bit acc = 0;
      in_valid = 1'b1;
      in_sop = sop;
      in_data = d;
      for (int i = 0; i < 5000 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_sop = 1'b0;
      n_checks++;
      if (!acc) begin
         n_fail++;
         $display("FAIL send_timeout: word %h never accepted, required acceptance", d);
      end
   endtask

   task automatic send_frame(input int n, input bit rnd, input int base);
      for (int i = 0; i < n; i++) begin
         if (rnd && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
         send(i == 0, rnd ? DW'($urandom) : DW'(base + i));
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      // two back-to-back frames, shown from the second frame period onward
      send_frame(FRAME_PX, 0, 1);
      send_frame(FRAME_PX, 0, 1);
      idle(3 * HT * VT);
      pulse_clr();
      // truncated frame: the second half underflows
      send_frame(FRAME_PX / 2, 0, 1);
      idle(2 * HT * VT);
      pulse_clr();
      // stale words ahead of a sop are discarded
      repeat (3) send(1'b0, DW'(24'h0000aa));
      send_frame(FRAME_PX, 0, 100);
      send_frame(FRAME_PX, 0, 200);
      idle(2 * HT * VT);
      for (int ep = 0; ep < 40; ep++) begin
         case ($urandom_range(0, 4))
            0, 1:    send_frame(FRAME_PX, 1, 0);
            2:       send_frame(int'($urandom_range(1, FRAME_PX - 1)), 1, 0);
            3:       repeat ($urandom_range(1, 3)) send(1'b0, DW'($urandom));
            default: begin
               idle(int'($urandom_range(1, HT * VT)));
               pulse_clr();
            end
         endcase
      end
`ifdef VGA_TEST_PATTERN_EN
      repeat (2) send(1'b0, DW'(24'h123456));
      test_mode = 1'b1;
      idle(2 * HT * VT);
      pulse_clr();
      test_mode = 1'b0;
      send_frame(FRAME_PX, 0, 1);
      idle(HT * VT);
`endif
      idle(2 * HT * VT);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
